sqr_shift_add: RTL

SQR_SHIFT_ADD -- requirements
Module: sqr_shift_add

---
 rtl/sqr_shift_add_if.sv | 25 ++
 rtl/sqr_shift_add.sv | 93 +++++++++
 2 files changed

// File: rtl/sqr_shift_add_if.sv
// Handshake and result bundle for the shift-add squarer.
interface sqr_shift_add_if #(
    parameter int DW = 16,
    parameter int CW = $clog2(DW) + 1
);
    logic            sync_clr;
    logic            start;
    logic [DW-1:0]   operand;
    logic            ready;
    logic            busy;
    logic            done;
    logic [2*DW-1:0] result;
    logic [CW-1:0]   iter;
    logic            flag_last;

    modport master (
        output sync_clr, start, operand,
        input  ready, busy, done, result, iter, flag_last
    );

    modport slave (
        input  sync_clr, start, operand,
        output ready, busy, done, result, iter, flag_last
    );
endinterface

// File: rtl/sqr_shift_add.sv
// Iterative unsigned squarer: one shift-add step per clock,
// DW steps per operand, result held until the next completion.
module sqr_shift_add #(
    parameter int DW = 16,
    parameter int CW = $clog2(DW) + 1
) (
    input logic            clk,
    input logic            rst,
    sqr_shift_add_if.slave bus
);
    localparam int PW = 2 * DW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   iter_q, iter_d;
    logic [DW-1:0]   mcand_q, mcand_d;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   result_q, result_d;
    logic            last;

    assign last = (iter_q == CW'(DW - 1));

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (bus.sync_clr) begin
            state_d = IDLE;
            iter_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand_d  = bus.operand;
                        mplier_d = bus.operand;
                        acc_d    = '0;
                        iter_d   = '0;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (mplier_q[0])
                        acc_d = acc_q + (PW'(mcand_q) << iter_q);
                    mplier_d = mplier_q >> 1;
                    if (last) begin
                        // final partial product folds straight into result
                        result_d = acc_d;
                        iter_d   = '0;
                        state_d  = DONE;
                    end else begin
                        iter_d = iter_q + CW'(1);
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            iter_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.iter      = iter_q;
    assign bus.flag_last = (state_q == RUN) && last;
endmodule
